fsqrt_wb_ctrl: RTL



---
 rtl/fsqrt_wb_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fsqrt_wb_ctrl.sv
// Issue/writeback controller around the fixed-latency fsqrt pipeline.
// Tracks tags alongside fsqrt, buffers results in a FIFO, and issues only when a FIFO slot is guaranteed.
module fsqrt_wb_ctrl #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_a,
    output logic [31:0]      sq_a,
    output logic             sq_en,
    input  logic [31:0]      sq_res,
    input  logic             sq_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int WU_W  = $clog2(LATENCY + 1);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    logic [WU_W-1:0]   wu_cnt;
    logic              wu_done;

    logic [LATENCY-1:0] pipe_vld;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];

    logic [TAG_W-1:0]  fifo_tag  [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [INF_W-1:0]  inflight;
    logic [SUM_W-1:0]  occupancy;
    logic              push;
    logic              pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_vld[i]);
        end
    end

    // A result leaving the pipe this cycle still holds its credit: no bypass.
    assign wu_done   = (wu_cnt == '0);
    assign occupancy = SUM_W'(count) + SUM_W'(inflight);
    assign req_ready = wu_done && (occupancy < SUM_W'(DEPTH));

    assign sq_a  = req_a;
    assign sq_en = req_valid & req_ready;

    assign push     = pipe_vld[LATENCY-1];
    assign wb_valid = (count != '0);
    assign pop      = wb_valid & wb_ready;
    assign wb_tag   = fifo_tag[rd_ptr];
    assign wb_data  = fifo_data[rd_ptr];
    assign busy     = (inflight != '0) || (count != '0);

    // fsqrt's ready chain has no reset; holding sq_en low for LATENCY cycles flushes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wu_cnt <= WU_W'(LATENCY);
        end else if (!wu_done) begin
            wu_cnt <= wu_cnt - WU_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= sq_en;
            pipe_tag[0] <= req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_tag[i]  <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
                fifo_data[wr_ptr] <= sq_res;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The internal valid stays authoritative; a disagreement is only flagged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (wu_done && (sq_ready != pipe_vld[LATENCY-1])) begin
            err <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && (count == CNT_W'(DEPTH))));

endmodule
